op_arb: RTL and testbench
=========================

OP_ARB -- requirements
Module: op_arb

Interface
REQ-001 Parameter NUM_SW_INST, default 5, meaning number of switch-instance op channels.
REQ-002 Parameter OP_WIDTH, default 32, meaning op word width.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning per-channel op FIFO entries; power of two, 2 minimum.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  NUM_SW_INST  per-channel op offer.
REQ-007 in_op  input  NUM_SW_INST x OP_WIDTH  per-channel op word: [21:17] addr, [16] wr/rd, [15:8] wr data, [7:0] op id, [31:22] reserved.
REQ-008 in_ready  output  NUM_SW_INST  per-channel accept; high when that channel's FIFO is not full.
REQ-009 op_out  output  OP_WIDTH  granted op word, fed to the decoder's op_in.
REQ-010 idx_out  output  (NUM_SW_INST>>1)+1  granted channel index, fed to the decoder's fifo_idx.
REQ-011 valid_out  output  1  single-cycle grant strobe, fed to the decoder's valid_in.
REQ-012 fifo_empty  output  NUM_SW_INST  per-channel FIFO empty flag.

Function
REQ-013 A channel write occurs on a cycle with in_valid[i] and in_ready[i] both high; in_ready[i] depends only on registered FIFO count.
REQ-014 Each channel FIFO stores words in arrival order; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-015 Arbiter FSM states: IDLE, GRANT, HOLD.
REQ-016 IDLE: if any FIFO non-empty, next state GRANT; else stay IDLE.
REQ-017 GRANT entry cycle: valid_out=1, op_out=head word of winner, idx_out=winner; winner FIFO popped at end of this cycle.
REQ-018 GRANT always goes to HOLD; HOLD keeps op_out and idx_out unchanged, valid_out=0, because the decoder samples op_in one cycle after valid_in.
REQ-019 HOLD goes to GRANT if any FIFO non-empty (including writes landed by then), else IDLE; valid_out therefore never high on two consecutive cycles; peak throughput one op per 2 cycles.
REQ-020 Winner selection round-robin: search starts at last winner +1, wraps at NUM_SW_INST-1 to 0; first non-empty channel wins; after reset pointer searches from channel 0.
REQ-021 op_out, idx_out, valid_out are registered outputs; no combinational path from in_* to them.
REQ-022 Simultaneous write and pop on a full FIFO: pop frees nothing that cycle (in_ready already low); write on a FIFO being popped with count < FIFO_DEPTH is accepted, count unchanged.
REQ-023 In IDLE, op_out and idx_out hold last granted values.

Reset
REQ-024 rst_n low asynchronously clears: FIFO pointers and counts (all FIFOs empty, fifo_empty all 1s, in_ready all 1s), FSM to IDLE, RR pointer to start at 0, op_out=0, idx_out=0, valid_out=0.
REQ-025 Reset mid-HOLD or mid-GRANT discards all buffered ops; no valid_out until 2 cycles after a write following deassertion.
REQ-026 FIFO data storage need not be reset.

Configuration
REQ-027 Macro OP_ARB_ID_FILTER_EN: defined -> ops with op id [7:0]==0 are dropped at the FIFO write (in_ready unaffected, no storage, never granted); undefined -> all accepted ops are stored and granted.

Verification
REQ-028 Single op 0x0025_AB07 on channel 2 from idle -> valid_out 2 cycles later, idx_out=2, op_out=0x0025_AB07 held for the valid cycle and the next.
REQ-029 Channels 0,1,4 each hold one op, all written same cycle -> grants in order 0,1,4 on alternating cycles, valid_out never back-to-back.
REQ-030 Channel 3 written FIFO_DEPTH+1 times without grants possible (held in reset-free idle with arbiter busy) -> in_ready[3] low at count 4, 5th write not stored, ops emerge in write order.
REQ-031 rst_n pulsed low during HOLD with 3 ops buffered -> outputs 0 immediately, fifo_empty all 1s, no further valid_out.
REQ-032 With OP_ARB_ID_FILTER_EN defined, write op id 0x00 then 0x11 on channel 1 -> exactly one grant, op_out[7:0]=0x11; undefined -> two grants.

Source files
------------

// File: rtl/op_arb.sv
// Round-robin arbiter draining per-channel op FIFOs into a decoder, one grant per two cycles.
// Optional build macro OP_ARB_ID_FILTER_EN: drop ops whose op id [7:0] is zero at FIFO write.
//
// state | meaning
// IDLE  | all FIFOs empty, outputs hold last grant
// GRANT | valid_out high, winner head presented, winner popped at end of cycle
// HOLD  | op_out/idx_out held for the decoder's delayed sample, valid_out low
module op_arb #(
   parameter int NUM_SW_INST = 5,
   parameter int OP_WIDTH    = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_SW_INST-1:0]                 in_valid,
   input  logic [NUM_SW_INST-1:0][OP_WIDTH-1:0]   in_op,
   output logic [NUM_SW_INST-1:0]                 in_ready,
   output logic [OP_WIDTH-1:0]                    op_out,
   output logic [(NUM_SW_INST>>1):0]              idx_out,
   output logic                                   valid_out,
   output logic [NUM_SW_INST-1:0]                 fifo_empty
);

   localparam int IDX_W = (NUM_SW_INST >> 1) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      rr_q, rr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic                  valid_q, valid_d;

   logic [NUM_SW_INST-1:0] ne_w;
   logic [NUM_SW_INST-1:0] ready_w;
   logic [OP_WIDTH-1:0]    head_w [NUM_SW_INST];
   logic [NUM_SW_INST-1:0] rot;
   logic [IDX_W-1:0]       sel;
   logic [OP_WIDTH-1:0]    head_sel;
   logic                   found;
   int                     c;

   for (genvar g = 0; g < NUM_SW_INST; g++) begin : g_ch
      logic [OP_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0]    cnt_q;
      logic                store, pop;

      assign ready_w[g] = (cnt_q != CNT_W'(FIFO_DEPTH));
      assign ne_w[g]    = (cnt_q != '0);
`ifdef OP_ARB_ID_FILTER_EN
      assign store = in_valid[g] && ready_w[g] && (in_op[g][7:0] != 8'h00);
`else
      assign store = in_valid[g] && ready_w[g];
`endif
      // idx_q always names the winner while in GRANT
      assign pop       = (state_q == ST_GRANT) && (idx_q == IDX_W'(g));
      assign head_w[g] = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
         if (store) mem_q[wr_ptr_q] <= in_op[g];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (store && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!store && pop) cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // Round-robin pick: rotate the non-empty vector so bit 0 is the search start
   always_comb begin
      rot      = NUM_SW_INST'({ne_w, ne_w} >> rr_q);
      found    = 1'b0;
      sel      = '0;
      c        = 0;
      head_sel = '0;
      for (int k = 0; k < NUM_SW_INST; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            c     = int'(rr_q) + k;
            if (c >= NUM_SW_INST) c = c - NUM_SW_INST;
            sel   = IDX_W'(c);
         end
      end
      for (int k = 0; k < NUM_SW_INST; k++) begin
         if (sel == IDX_W'(k)) head_sel = head_w[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|ne_w) state_d = ST_GRANT;
         ST_GRANT: state_d = ST_HOLD;
         ST_HOLD:  state_d = (|ne_w) ? ST_GRANT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are loaded on entry to GRANT so they appear registered during GRANT
   always_comb begin
      valid_d = (state_d == ST_GRANT);
      op_d    = op_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      if (valid_d) begin
         op_d  = head_sel;
         idx_d = sel;
         rr_d  = (sel == IDX_W'(NUM_SW_INST - 1)) ? '0 : sel + IDX_W'(1);
      end
   end

   assign in_ready   = ready_w;
   assign fifo_empty = ~ne_w;
   assign op_out     = op_q;
   assign idx_out    = idx_q;
   assign valid_out  = valid_q;

endmodule

// File: tb/tb_op_arb.sv
// Directed self-checking bench for op_arb with default parameters (5 channels, depth 4).
module tb_op_arb;

   logic             clk;
   logic             rst_n;
   logic [4:0]       in_valid;
   logic [4:0][31:0] in_op;
   logic [4:0]       in_ready;
   logic [31:0]      op_out;
   logic [2:0]       idx_out;
   logic             valid_out;
   logic [4:0]       fifo_empty;

   int n_assert = 0;
   int n_fail   = 0;

   op_arb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_op      (in_op),
      .in_ready   (in_ready),
      .op_out     (op_out),
      .idx_out    (idx_out),
      .valid_out  (valid_out),
      .fifo_empty (fifo_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = '0;
      in_op    = '0;
      rst_n    = 1'b0;
      step();
      rst_n    = 1'b1;
      step();
   endtask

   logic [31:0] exp_op  [5];
   logic [2:0]  exp_idx [5];
   int          gi;
   int          grants;
   logic [31:0] last_op;

   initial begin
      in_valid = '0;
      in_op    = '0;
      rst_n    = 1'b0;
      #2;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_op", op_out, 32'd0);
      check("rst_idx", 32'(idx_out), 32'd0);
      check("rst_empty", 32'(fifo_empty), 32'h1f);
      check("rst_ready", 32'(in_ready), 32'h1f);
      step();
      rst_n = 1'b1;
      step();

      // single op on channel 2
      in_valid    = 5'b00100;
      in_op[2]    = 32'h0025_AB07;
      step();
      in_valid    = '0;
      check("t1_e0_valid", 32'(valid_out), 32'd0);
      check("t1_e0_empty", 32'(fifo_empty), 32'h1b);
      step();
      check("t1_grant_valid", 32'(valid_out), 32'd1);
      check("t1_grant_idx", 32'(idx_out), 32'd2);
      check("t1_grant_op", op_out, 32'h0025_AB07);
      step();
      check("t1_hold_valid", 32'(valid_out), 32'd0);
      check("t1_hold_idx", 32'(idx_out), 32'd2);
      check("t1_hold_op", op_out, 32'h0025_AB07);
      check("t1_hold_empty", 32'(fifo_empty), 32'h1f);
      step();
      check("t1_idle_valid", 32'(valid_out), 32'd0);
      check("t1_idle_op", op_out, 32'h0025_AB07);

      // channels 0,1,4 written together
      do_reset();
      in_valid = 5'b10011;
      in_op[0] = 32'h0000_A000;
      in_op[1] = 32'h0000_A101;
      in_op[4] = 32'h0000_A404;
      step();
      in_valid = '0;
      exp_op[0] = 32'h0000_A000; exp_idx[0] = 3'd0;
      exp_op[1] = 32'h0000_A101; exp_idx[1] = 3'd1;
      exp_op[2] = 32'h0000_A404; exp_idx[2] = 3'd4;
      gi = 0;
      for (int e = 1; e <= 7; e++) begin
         step();
         if (e % 2 == 1 && e <= 5) begin
            check("t2_valid", 32'(valid_out), 32'd1);
            check("t2_idx", 32'(idx_out), 32'(exp_idx[gi]));
            check("t2_op", op_out, exp_op[gi]);
            gi++;
         end else begin
            check("t2_gap_valid", 32'(valid_out), 32'd0);
         end
      end
      check("t2_empty", 32'(fifo_empty), 32'h1f);

      // channel 3 overfilled while the arbiter serves 0,1,2
      do_reset();
      in_valid = 5'b01111;
      in_op[0] = 32'h0000_B000;
      in_op[1] = 32'h0000_B101;
      in_op[2] = 32'h0000_B202;
      in_op[3] = 32'h0000_C300;
      step();
      in_valid = 5'b01000;
      in_op[3] = 32'h0000_C301;
      step();
      in_op[3] = 32'h0000_C302;
      step();
      in_op[3] = 32'h0000_C303;
      step();
      check("t3_full_ready", 32'(in_ready), 32'h17);
      check("t3_full_empty", 32'(fifo_empty), 32'h11);
      in_op[3] = 32'h0000_C304;
      step();
      in_valid = '0;
      check("t3_5th_ready", 32'(in_ready), 32'h17);
      exp_op[0] = 32'h0000_B202; exp_idx[0] = 3'd2;
      exp_op[1] = 32'h0000_C300; exp_idx[1] = 3'd3;
      exp_op[2] = 32'h0000_C301; exp_idx[2] = 3'd3;
      exp_op[3] = 32'h0000_C302; exp_idx[3] = 3'd3;
      exp_op[4] = 32'h0000_C303; exp_idx[4] = 3'd3;
      gi = 0;
      for (int e = 5; e <= 17; e++) begin
         step();
         if (e % 2 == 1 && e <= 13) begin
            check("t3_valid", 32'(valid_out), 32'd1);
            check("t3_idx", 32'(idx_out), 32'(exp_idx[gi]));
            check("t3_op", op_out, exp_op[gi]);
            gi++;
         end else begin
            check("t3_gap_valid", 32'(valid_out), 32'd0);
         end
         if (e == 8) check("t3_ready_after_pop", 32'(in_ready), 32'h1f);
      end
      check("t3_empty", 32'(fifo_empty), 32'h1f);

      // reset during HOLD with three ops still buffered
      do_reset();
      in_valid = 5'b01111;
      in_op[0] = 32'h0000_D000;
      in_op[1] = 32'h0000_D101;
      in_op[2] = 32'h0000_D202;
      in_op[3] = 32'h0000_D303;
      step();
      in_valid = '0;
      step();
      check("t4_grant_op", op_out, 32'h0000_D000);
      step();
      check("t4_hold_empty", 32'(fifo_empty), 32'h11);
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", 32'(valid_out), 32'd0);
      check("t4_rst_op", op_out, 32'd0);
      check("t4_rst_idx", 32'(idx_out), 32'd0);
      check("t4_rst_empty", 32'(fifo_empty), 32'h1f);
      check("t4_rst_ready", 32'(in_ready), 32'h1f);
      step();
      rst_n = 1'b1;
      grants = 0;
      for (int e = 0; e < 6; e++) begin
         step();
         if (valid_out === 1'b1) grants++;
      end
      check("t4_no_grant", 32'(grants), 32'd0);

      // op id zero then 0x11 on channel 1
      do_reset();
      in_valid = 5'b00010;
      in_op[1] = 32'h0000_5500;
      step();
      in_op[1] = 32'h0000_6611;
      step();
      in_valid = '0;
      grants  = 0;
      last_op = '0;
      if (valid_out === 1'b1) begin
         grants++;
         last_op = op_out;
      end
      for (int e = 0; e < 9; e++) begin
         step();
         if (valid_out === 1'b1) begin
            grants++;
            last_op = op_out;
         end
      end
`ifdef OP_ARB_ID_FILTER_EN
      check("t5_grants", 32'(grants), 32'd1);
`else
      check("t5_grants", 32'(grants), 32'd2);
`endif
      check("t5_last_id", 32'(last_op[7:0]), 32'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
